vesp_boot_loader: RTL and testbench
===================================

Name: vesp_boot_loader

Overview:
- Program loader directly upstream of the vesp1 core. Receives a byte stream (host link/UART receiver) and writes 16-bit words into vesp1 program memory through a single write port.
- Holds the core in reset until a frame loads with a valid checksum, then releases it.
- Replaces the bench-side direct memory pokes used for bring-up.

Parameters:
- WORD_SIZE, 16, memory word width; fixed at 16 for the 2-byte word format.
- ADDR_SIZE, 12, memory address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1023, max idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts byte this cycle; transfer happens when in_valid & in_ready.
- mem_we  out  1  memory write request.
- mem_addr  out  ADDR_SIZE  write address.
- mem_wdata  out  WORD_SIZE  write data.
- mem_ready  in  1  memory accepts write this cycle; transfer happens when mem_we & mem_ready.
- cpu_rst_n  out  1  active-low reset to vesp1; 0 until successful load.
- done  out  1  frame loaded, checksum good; sticky.
- err  out  1  one-cycle pulse on checksum/length/timeout error.
- words_loaded  out  ADDR_SIZE+1  words written in current frame.

Behaviour:
- Reset (async, rst=0): state IDLE; in_ready=0 during reset, 1 afterwards; mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, err=0, words_loaded=0, checksum=0, timeout counter=0.
- Frame format: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words (high byte first), then CSUM.
  - Start address = {ADDR_H,ADDR_L}[ADDR_SIZE-1:0]; upper bits are ignored.
- Checksum: 8-bit running sum of every byte after SYNC, including CSUM. The frame is good iff the sum mod 256 is 0.
- FSM transitions (each on an accepted byte unless noted):
  - IDLE: any byte other than SYNC_BYTE is discarded. SYNC_BYTE -> ADDR_H and clears checksum and words_loaded.
  - ADDR_H -> ADDR_L -> CNT_H -> CNT_L.
  - CNT_L: count == 0 -> CSUM; count > 2^ADDR_SIZE -> err pulse, IDLE; otherwise -> DATA_H.
  - DATA_H -> DATA_L.
  - DATA_L -> WRITE. Registers mem_wdata; mem_we=1 the cycle after the low byte is accepted.
  - WRITE: in_ready=0 and mem_we held with stable addr/data until mem_ready=1. On that cycle: mem_we drops next cycle, mem_addr increments, words_loaded increments. Then -> CSUM if last word, else DATA_H.
  - CSUM: good -> DONE; bad -> err pulse, IDLE. cpu_rst_n stays 0 on a bad frame.
  - DONE: done=1, cpu_rst_n=1, in_ready=0. Stays here until rst.
- Latency: with mem_ready tied high, a word is written exactly 1 cycle after its low byte is accepted. in_ready is low for 2 cycles per word (WRITE handshake).
- Address wrap: mem_addr increments mod 2^ADDR_SIZE (4095 -> 0). A count of exactly 4096 is legal.
- Timeout: in any state except IDLE and DONE, the counter increments each cycle without an accepted byte and clears on an accepted byte. Reaching TIMEOUT -> err pulse, IDLE.
  - The counter is frozen in WRITE; memory stalls never time out.
- A SYNC_BYTE value arriving mid-frame is treated as data, not a restart.
- Reset mid-frame: immediate return to reset values. Memory words already written are not rolled back.

Decomposition:
- Shared package vesp_pkg: WORD_SIZE, ADDR_SIZE, SYNC_BYTE, and the loader state enum encoding. The vesp1 core also uses WORD_SIZE and ADDR_SIZE.
- One sub-module: vesp_boot_timeout, a loadable down-counter with clear/enable/expire, reusable for future link watchdogs.
- The FSM, byte assembly and checksum stay in the top module.

Test Plan:
1. Frame A5 00 02 00 06 20 00 00 08 20 01 00 0B 00 00 70 00 34, mem_ready=1 -> memory[2..7] = 2000,0008,2001,000B,0000,7000; words_loaded=6; done=1 and cpu_rst_n=1 one cycle after CSUM is accepted.
2. Same frame with CSUM=35 -> err pulses once, done=0, cpu_rst_n=0, state IDLE. A subsequent good frame still loads correctly.
3. mem_ready held 0 for 5 cycles on the first word -> mem_we, mem_addr=002, mem_wdata=2000 stable throughout; in_ready=0; no timeout; load completes.
4. Address FFF, count 2, words 1111,2222, correct CSUM -> memory[4095]=1111, memory[0]=2222, done=1.
5. Stall in_valid for TIMEOUT cycles after CNT_H -> err pulse, IDLE. Leading garbage bytes 00 FF before A5 are ignored.
6. Assert rst mid-DATA phase -> all outputs return to reset values asynchronously; count 0 frame A5 01 00 00 00 FF -> done=1 with no mem_we.

Source files
------------

// File: rtl/vesp_pkg.sv
// vesp1 shared constants: memory geometry, frame sync marker
// and the boot loader state encoding.
package vesp_pkg;

   localparam int WORD_SIZE = 16;
   localparam int ADDR_SIZE = 12;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_CNT_H,
      S_CNT_L,
      S_DATA_H,
      S_DATA_L,
      S_WRITE,
      S_CSUM,
      S_DONE
   } ld_state_e;

endpackage

// File: rtl/vesp_boot_loader_if.sv
// Byte-stream input and program-memory write port of the
// vesp1 boot loader; master drives the stream and memory ready.
interface vesp_boot_loader_if;
   import vesp_pkg::*;

   logic                 in_valid;
   logic [7:0]           in_data;
   logic                 in_ready;
   logic                 mem_we;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic                 mem_ready;

   modport slave (
      input  in_valid, in_data, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_data, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/vesp_boot_timeout.sv
// Loadable down-counter watchdog: clr_i reloads, en_i counts
// down, expire_o flags the step that would reach zero.
module vesp_boot_timeout #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] load_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && !clr_i && (cnt_q == W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = load_i;
      else if (en_i && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vesp_boot_loader.sv
// vesp1 program loader: parses SYNC/addr/count/words/csum frames
// into memory writes and releases the core on a good checksum.
module vesp_boot_loader
   import vesp_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   vesp_boot_loader_if.slave    bus,
   output logic                 cpu_rst_n,
   output logic                 done,
   output logic                 err,
   output logic [ADDR_SIZE:0]   words_loaded
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [15:0] MAX_CNT = 16'(1 << ADDR_SIZE);

   ld_state_e            state_q, state_d;
   logic                 ready_q, ready_d;
   logic                 err_q, err_d;
   logic [7:0]           csum_q, csum_d;
   logic [7:0]           hi_q, hi_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [ADDR_SIZE:0]   rem_q, rem_d;
   logic [ADDR_SIZE:0]   wl_q, wl_d;

   logic        acc;
   logic [15:0] cnt_full;
   logic        to_en;
   logic        to_exp;

   assign acc      = bus.in_valid && ready_q;
   assign cnt_full = {hi_q, bus.in_data};

   // stalls in WRITE and the idle/done states never count
   assign to_en = !acc && state_q != S_IDLE
               && state_q != S_WRITE && state_q != S_DONE;

   vesp_boot_timeout #(
      .W (TW)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst),
      .load_i   (TW'(TIMEOUT)),
      .clr_i    (acc),
      .en_i     (to_en),
      .expire_o (to_exp)
   );

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      csum_d  = csum_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rem_d   = rem_q;
      wl_d    = wl_q;

      if (acc && state_q != S_IDLE)
         csum_d = csum_q + bus.in_data;

      unique case (state_q)
         S_IDLE: begin
            if (acc && bus.in_data == SYNC_BYTE) begin
               state_d = S_ADDR_H;
               csum_d  = '0;
               wl_d    = '0;
            end
         end
         S_ADDR_H: begin
            if (acc) begin
               hi_d    = bus.in_data;
               state_d = S_ADDR_L;
            end
         end
         S_ADDR_L: begin
            if (acc) begin
               addr_d  = ADDR_SIZE'({hi_q, bus.in_data});
               state_d = S_CNT_H;
            end
         end
         S_CNT_H: begin
            if (acc) begin
               hi_d    = bus.in_data;
               state_d = S_CNT_L;
            end
         end
         S_CNT_L: begin
            if (acc) begin
               if (cnt_full == '0) begin
                  state_d = S_CSUM;
               end else if (cnt_full > MAX_CNT) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  rem_d   = cnt_full[ADDR_SIZE:0];
                  state_d = S_DATA_H;
               end
            end
         end
         S_DATA_H: begin
            if (acc) begin
               hi_d    = bus.in_data;
               state_d = S_DATA_L;
            end
         end
         S_DATA_L: begin
            if (acc) begin
               wdata_d = {hi_q, bus.in_data};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus.mem_ready) begin
               addr_d  = addr_q + ADDR_SIZE'(1);
               wl_d    = wl_q + (ADDR_SIZE+1)'(1);
               rem_d   = rem_q - (ADDR_SIZE+1)'(1);
               state_d = (rem_q == (ADDR_SIZE+1)'(1))
                       ? S_CSUM : S_DATA_H;
            end
         end
         S_CSUM: begin
            if (acc) begin
               if (csum_d == 8'h00) begin
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      if (to_exp) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end

      // one extra bubble after each write handshake
      ready_d = state_d != S_WRITE && state_d != S_DONE
             && state_q != S_WRITE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         csum_q  <= '0;
         hi_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rem_q   <= '0;
         wl_q    <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         csum_q  <= csum_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rem_q   <= rem_d;
         wl_q    <= wl_d;
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.mem_we    = state_q == S_WRITE;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign done          = state_q == S_DONE;
   assign cpu_rst_n     = state_q == S_DONE;
   assign err           = err_q;
   assign words_loaded  = wl_q;

endmodule

// File: tb/tb_vesp_boot_loader.sv
// Frame-level bench for vesp_boot_loader: builds frames from words,
// predicts the write stream and memory image, checks every cycle.
module tb_vesp_boot_loader;
   import vesp_pkg::*;

   localparam int TO = 1023;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cpu_rst_n, done, err;
   logic [ADDR_SIZE:0] words_loaded;

   vesp_boot_loader_if bus();

   vesp_boot_loader #(
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst_n),
      .bus          (bus),
      .cpu_rst_n    (cpu_rst_n),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int err_cnt = 0;
   int wl_model = 0;
   int stall_left = 0;
   bit rand_mode = 1'b0;

   logic [27:0] exp_q[$];
   logic [7:0]  fq[$];
   logic [15:0] wbuf[$];
   logic [15:0] mem [0:4095];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // frame = SYNC, addr, count, words, csum making the byte sum 0
   task automatic build(input logic [15:0] a16, input bit bad);
      logic [7:0]  s;
      logic [15:0] n;
      s = 8'h00;
      n = 16'(wbuf.size());
      fq.delete();
      fq.push_back(SYNC_BYTE);
      fq.push_back(a16[15:8]);
      fq.push_back(a16[7:0]);
      fq.push_back(n[15:8]);
      fq.push_back(n[7:0]);
      foreach (wbuf[i]) begin
         fq.push_back(wbuf[i][15:8]);
         fq.push_back(wbuf[i][7:0]);
         exp_q.push_back({12'(a16[11:0] + i), wbuf[i]});
      end
      for (int i = 1; i < fq.size(); i++) s = s + fq[i];
      fq.push_back((8'h00 - s) ^ (bad ? 8'h01 : 8'h00));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap,
                            output int w);
      w = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) chk("byte_accept_bound", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_frame();
      int w;
      bit after_lo;
      after_lo = 1'b0;
      wl_model = 0;
      for (int i = 0; i < fq.size(); i++) begin
         send_byte(fq[i], rand_mode ? int'($urandom_range(0, 2)) : 0, w);
         if (!rand_mode) chk("in_ready_gap", w, after_lo ? 2 : 0);
         after_lo = 1'b0;
         if (i >= 6 && i <= fq.size() - 2 && i % 2 == 0) begin
            chk("we_after_low_byte", bus.mem_we, 1);
            after_lo = 1'b1;
         end
      end
   endtask

   task automatic do_reset(input bit chkv);
      #2 rst_n = 1'b0;
      #1;
      if (chkv) begin
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_mem_we", bus.mem_we, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_mem_wdata", bus.mem_wdata, 0);
         chk("rst_cpu_rst_n", cpu_rst_n, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_words_loaded", words_loaded, 0);
      end
      exp_q.delete();
      wl_model = 0;
      stall_left = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("in_ready_after_rst", bus.in_ready, 1);
   endtask

   // memory side: optional forced stall, else ready or random
   initial begin
      bus.mem_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.mem_we && stall_left > 0) begin
            bus.mem_ready = 1'b0;
            stall_left--;
         end else begin
            bus.mem_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   initial begin
      logic [27:0] prev;
      logic [27:0] e;
      bit stall_prev;
      stall_prev = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (err) err_cnt++;
            if (stall_prev) begin
               chk("we_hold", bus.mem_we, 1);
               chk("bus_hold", {bus.mem_addr, bus.mem_wdata}, prev);
            end
            if (bus.mem_we) chk("in_ready_in_write", bus.in_ready, 0);
            if (bus.mem_we && bus.mem_ready) begin
               chk("write_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, e);
                  chk("words_loaded_at_write", words_loaded, wl_model);
               end
               wl_model++;
               mem[bus.mem_addr] = bus.mem_wdata;
            end
            stall_prev = bus.mem_we && !bus.mem_ready;
            prev = {bus.mem_addr, bus.mem_wdata};
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int w;
      int n;
      logic [15:0] a16;
      logic [11:0] idx;
      logic [7:0]  t1 [18];
      logic [15:0] lit [6];
      t1  = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h06, 8'h20, 8'h00, 8'h00, 8'h08,
              8'h20, 8'h01, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h70, 8'h00, 8'h34};
      lit = '{16'h2000, 16'h0008, 16'h2001, 16'h000B, 16'h0000, 16'h7000};
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      do_reset(1);

      // basic six-word load
      wbuf = '{16'h2000, 16'h0008, 16'h2001, 16'h000B, 16'h0000, 16'h7000};
      build(16'h0002, 0);
      for (int i = 0; i < 18; i++) chk("model_frame_t1", fq[i], t1[i]);
      e0 = err_cnt;
      send_frame();
      chk("t1_done", done, 1);
      chk("t1_cpu_rst_n", cpu_rst_n, 1);
      chk("t1_in_ready_done", bus.in_ready, 0);
      chk("t1_words_loaded", words_loaded, 6);
      for (int i = 0; i < 6; i++) chk("t1_mem", mem[2 + i], lit[i]);
      chk("t1_err", err_cnt - e0, 0);
      chk("t1_writes_left", exp_q.size(), 0);

      // bad checksum, over-length count, then a good frame
      do_reset(0);
      build(16'h0002, 1);
      chk("model_csum_bad", fq[17], 8'h35);
      e0 = err_cnt;
      send_frame();
      repeat (3) @(negedge clk);
      chk("t2_err_pulse", err_cnt - e0, 1);
      chk("t2_done", done, 0);
      chk("t2_cpu_rst_n", cpu_rst_n, 0);
      fq = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h01};
      send_frame();
      repeat (3) @(negedge clk);
      chk("t2_len_err", err_cnt - e0, 2);
      wbuf = '{16'h1357, 16'hA5A5, 16'h0F0F};
      build(16'h0123, 0);
      send_frame();
      chk("t2_done_after", done, 1);
      chk("t2_words_loaded", words_loaded, 3);
      foreach (wbuf[i]) chk("t2_mem", mem[12'h123 + i], wbuf[i]);
      chk("t2_err_total", err_cnt - e0, 2);

      // memory stalls: short on word 0, longer than TIMEOUT on word 1
      do_reset(0);
      wbuf = '{16'h2000, 16'h0008, 16'h2001, 16'h000B, 16'h0000, 16'h7000};
      build(16'h0002, 0);
      e0 = err_cnt;
      wl_model = 0;
      stall_left = 5;
      for (int i = 0; i < fq.size(); i++) begin
         send_byte(fq[i], 0, w);
         if (i == 6) begin
            chk("t3_addr", bus.mem_addr, 12'h002);
            chk("t3_wdata", bus.mem_wdata, 16'h2000);
         end
         if (i == 7) chk("t3_short_stall_wait", w, 7);
         if (i == 8) stall_left = TO + 7;
      end
      chk("t3_done", done, 1);
      chk("t3_no_timeout", err_cnt - e0, 0);
      chk("t3_words_loaded", words_loaded, 6);

      // address wrap 4095 -> 0
      do_reset(0);
      wbuf = '{16'h1111, 16'h2222};
      build(16'h0FFF, 0);
      chk("model_csum_wrap", fq[9], 8'h8A);
      send_frame();
      chk("t4_done", done, 1);
      chk("t4_mem_fff", mem[4095], 16'h1111);
      chk("t4_mem_000", mem[0], 16'h2222);
      chk("t4_words_loaded", words_loaded, 2);

      // garbage before sync, then an idle stall after CNT_H
      do_reset(0);
      e0 = err_cnt;
      fq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < fq.size(); i++) send_byte(fq[i], 0, w);
      repeat (TO - 1) @(posedge clk);
      #1 chk("t5_err_early", err, 0);
      @(posedge clk);
      #1 chk("t5_err_at_timeout", err, 1);
      @(posedge clk);
      #1 chk("t5_err_one_cycle", err, 0);
      chk("t5_err_count", err_cnt - e0, 1);
      chk("t5_done", done, 0);
      wbuf = '{16'hBEEF, 16'h00A5};
      build(16'h00A0, 0);
      send_frame();
      chk("t5_done_after", done, 1);
      chk("t5_mem", mem[12'h0A1], 16'h00A5);

      // count 4096 accepted, reset mid-frame, then an empty frame
      do_reset(0);
      e0 = err_cnt;
      fq = '{8'hA5, 8'h00, 8'h10, 8'h10, 8'h00, 8'h12, 8'h34, 8'h56};
      exp_q.push_back({12'h010, 16'h1234});
      wl_model = 0;
      for (int i = 0; i < fq.size(); i++) send_byte(fq[i], 0, w);
      chk("t6_max_count_ok", err_cnt - e0, 0);
      chk("t6_first_write", exp_q.size(), 0);
      chk("t6_words_loaded", words_loaded, 1);
      do_reset(1);
      fq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
      send_frame();
      chk("t6_done", done, 1);
      chk("t6_cpu_rst_n", cpu_rst_n, 1);
      chk("t6_words_loaded_zero", words_loaded, 0);

      // randomized frames with gaps, garbage, stalls and bad frames
      for (int it = 0; it < 12; it++) begin
         do_reset(0);
         rand_mode = 1'b1;
         e0 = err_cnt;
         repeat ($urandom_range(0, 2)) begin
            a16[7:0] = 8'($urandom_range(0, 255));
            if (a16[7:0] == SYNC_BYTE) a16[7:0] = 8'h5A;
            send_byte(a16[7:0], $urandom_range(0, 2), w);
         end
         if (it % 3 == 0) begin
            wbuf.delete();
            repeat ($urandom_range(1, 4)) wbuf.push_back(16'($urandom));
            build(16'($urandom), 1);
            send_frame();
            repeat (3) @(negedge clk);
            chk("rand_bad_err", err_cnt - e0, 1);
            chk("rand_bad_done", done, 0);
         end
         wbuf.delete();
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) wbuf.push_back(16'($urandom));
         if (it % 2 == 1) wbuf[0] = 16'hA5A5;
         a16 = 16'($urandom);
         build(a16, 0);
         send_frame();
         chk("rand_done", done, 1);
         chk("rand_cpu_rst_n", cpu_rst_n, 1);
         chk("rand_words_loaded", words_loaded, n);
         chk("rand_writes_left", exp_q.size(), 0);
         chk("rand_err", err_cnt - e0, (it % 3 == 0) ? 1 : 0);
         foreach (wbuf[i]) begin
            idx = 12'(a16[11:0] + i);
            chk("rand_mem", mem[idx], wbuf[i]);
         end
         rand_mode = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
